// File: rtl/game_ctrl.sv
// Game flow controller: start countdown, timed play, clear/over result and
// best-clear-time tracking. All outputs are registered.
module game_ctrl #(
    parameter int unsigned CNTDN_TICK = 99999999,
    parameter int unsigned CNTDN_LEN  = 3,
    parameter logic [11:0] TIME_LIMIT = 12'h999
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Goal,
    input  logic [3:0] i_Sec0,
    input  logic [3:0] i_Sec1,
    input  logic [3:0] i_Sec2,
    output logic       o_TimerEn,
    output logic [2:0] o_State,
    output logic [3:0] o_Cntdn,
    output logic       o_MoveEn,
    output logic [3:0] o_Disp0,
    output logic [3:0] o_Disp1,
    output logic [3:0] o_Disp2,
    output logic [3:0] o_Best0,
    output logic [3:0] o_Best1,
    output logic [3:0] o_Best2,
    output logic       o_BestValid,
    output logic       o_NewBest
);

    localparam int unsigned TW = (CNTDN_TICK > 0) ? $clog2(CNTDN_TICK + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CNTDN = 3'd1,
        PLAY  = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    cntdn_q, cntdn_d;
    logic          timer_en_q, timer_en_d;
    logic          move_en_q, move_en_d;
    logic [11:0]   disp_q, disp_d;
    logic [11:0]   best_q, best_d;
    logic          best_valid_q, best_valid_d;
    logic          new_best_q, new_best_d;
    logic [11:0]   sec;

    assign sec = {i_Sec2, i_Sec1, i_Sec0};

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        cntdn_d      = cntdn_q;
        disp_d       = disp_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_best_d   = new_best_q;

        unique case (state_q)
            IDLE: begin
                disp_d  = '0;
                cntdn_d = '0;
                if (i_Start) begin
                    state_d = CNTDN;
                    cntdn_d = 4'(CNTDN_LEN);
                    tick_d  = '0;
                end
            end
            CNTDN: begin
                disp_d = '0;
                if (tick_q == TW'(CNTDN_TICK)) begin
                    tick_d = '0;
                    if (cntdn_q <= 4'd1) begin
                        state_d = PLAY;
                        cntdn_d = '0;
                    end else begin
                        cntdn_d = cntdn_q - 4'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            PLAY: begin
                // Display tracks the timer; the value sampled on the exit cycle is what stays frozen.
                disp_d = sec;
                if (i_Goal) begin
                    state_d = CLEAR;
                    if (!best_valid_q || (sec < best_q)) begin
                        best_d       = sec;
                        best_valid_d = 1'b1;
                        new_best_d   = 1'b1;
                    end else begin
                        new_best_d   = 1'b0;
                    end
                end else if (sec == TIME_LIMIT) begin
                    state_d    = OVER;
                    new_best_d = 1'b0;
                end
            end
            CLEAR, OVER: begin
                if (i_Start) begin
                    state_d    = CNTDN;
                    cntdn_d    = 4'(CNTDN_LEN);
                    tick_d     = '0;
                    disp_d     = '0;
                    new_best_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                tick_d     = '0;
                cntdn_d    = '0;
                disp_d     = '0;
                new_best_d = 1'b0;
            end
        endcase

        timer_en_d = (state_d == PLAY);
        move_en_d  = (state_d == PLAY);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            cntdn_q      <= '0;
            timer_en_q   <= 1'b0;
            move_en_q    <= 1'b0;
            disp_q       <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            new_best_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            cntdn_q      <= cntdn_d;
            timer_en_q   <= timer_en_d;
            move_en_q    <= move_en_d;
            disp_q       <= disp_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_best_q   <= new_best_d;
        end
    end

    assign o_State     = state_q;
    assign o_Cntdn     = cntdn_q;
    assign o_TimerEn   = timer_en_q;
    assign o_MoveEn    = move_en_q;
    assign o_Disp0     = disp_q[3:0];
    assign o_Disp1     = disp_q[7:4];
    assign o_Disp2     = disp_q[11:8];
    assign o_Best0     = best_q[3:0];
    assign o_Best1     = best_q[7:4];
    assign o_Best2     = best_q[11:8];
    assign o_BestValid = best_valid_q;
    assign o_NewBest   = new_best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a short countdown (tick=3, len=3) and a
// time limit of 005.
module tb_game_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Goal = 1'b0;
    logic [3:0] i_Sec0 = '0, i_Sec1 = '0, i_Sec2 = '0;
    logic       o_TimerEn, o_MoveEn, o_BestValid, o_NewBest;
    logic [2:0] o_State;
    logic [3:0] o_Cntdn, o_Disp0, o_Disp1, o_Disp2, o_Best0, o_Best1, o_Best2;

    int total = 0;
    int bad   = 0;

    game_ctrl #(.CNTDN_TICK(3), .CNTDN_LEN(3), .TIME_LIMIT(12'h005)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Goal(i_Goal),
        .i_Sec0(i_Sec0), .i_Sec1(i_Sec1), .i_Sec2(i_Sec2),
        .o_TimerEn(o_TimerEn), .o_State(o_State), .o_Cntdn(o_Cntdn), .o_MoveEn(o_MoveEn),
        .o_Disp0(o_Disp0), .o_Disp1(o_Disp1), .o_Disp2(o_Disp2),
        .o_Best0(o_Best0), .o_Best1(o_Best1), .o_Best2(o_Best2),
        .o_BestValid(o_BestValid), .o_NewBest(o_NewBest)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_sec(input logic [11:0] s);
        {i_Sec2, i_Sec1, i_Sec0} = s;
    endtask

    // Pulse start, then walk the countdown checking value and duration;
    // optionally poke start/goal mid-countdown to show they are ignored.
    task automatic start_countdown(input bit inject);
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        chk("cntdn_state", 32'(o_State), 32'd1);
        chk("cntdn_first", 32'(o_Cntdn), 32'd3);
        chk("cntdn_disp", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'h000);
        chk("cntdn_newbest", 32'(o_NewBest), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            if (inject && (k == 2 || k == 6)) begin
                i_Start = 1'b1;
                i_Goal  = 1'b1;
            end
            step();
            i_Start = 1'b0;
            i_Goal  = 1'b0;
            chk("cntdn_val", 32'(o_Cntdn), 32'(3 - k / 4));
            chk("cntdn_hold", 32'(o_State), 32'd1);
            chk("cntdn_timer", 32'(o_TimerEn), 32'd0);
        end
        step();
        chk("play_state", 32'(o_State), 32'd2);
        chk("play_timer", 32'(o_TimerEn), 32'd1);
        chk("play_move", 32'(o_MoveEn), 32'd1);
        chk("play_cntdn", 32'(o_Cntdn), 32'd0);
    endtask

    task automatic goal_at(input logic [11:0] s, input logic [11:0] best, input logic nb);
        set_sec(s);
        i_Goal = 1'b1;
        step();
        i_Goal = 1'b0;
        chk("clear_state", 32'(o_State), 32'd3);
        chk("clear_disp", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'(s));
        chk("clear_best", 32'({o_Best2, o_Best1, o_Best0}), 32'(best));
        chk("clear_valid", 32'(o_BestValid), 32'd1);
        chk("clear_newbest", 32'(o_NewBest), 32'(nb));
        chk("clear_timer", 32'(o_TimerEn), 32'd0);
        chk("clear_move", 32'(o_MoveEn), 32'd0);
    endtask

    initial begin
        #3;
        chk("rst_state", 32'(o_State), 32'd0);
        chk("rst_timer", 32'(o_TimerEn), 32'd0);
        chk("rst_valid", 32'(o_BestValid), 32'd0);
        chk("rst_cntdn", 32'(o_Cntdn), 32'd0);
        step();
        i_Rst = 1'b1;
        repeat (3) step();
        chk("idle_wait", 32'(o_State), 32'd0);

        // First run: countdown with ignored pokes, then play and clear at 002
        start_countdown(1'b1);
        set_sec(12'h000);
        step();
        chk("disp_000", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'h000);
        set_sec(12'h001);
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        chk("play_start_ign", 32'(o_State), 32'd2);
        chk("disp_001", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'h001);
        goal_at(12'h002, 12'h002, 1'b1);
        set_sec(12'h003);
        step();
        chk("clear_hold_disp", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'h002);

        // Slower clear keeps best; faster clear replaces it; equal does not
        start_countdown(1'b0);
        goal_at(12'h004, 12'h002, 1'b0);
        start_countdown(1'b0);
        goal_at(12'h001, 12'h001, 1'b1);
        start_countdown(1'b0);
        goal_at(12'h001, 12'h001, 1'b0);

        // Time limit reached without goal
        start_countdown(1'b0);
        set_sec(12'h004);
        step();
        chk("pre_limit", 32'(o_State), 32'd2);
        set_sec(12'h005);
        step();
        chk("over_state", 32'(o_State), 32'd4);
        chk("over_disp", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'h005);
        chk("over_best", 32'({o_Best2, o_Best1, o_Best0}), 32'h001);
        chk("over_newbest", 32'(o_NewBest), 32'd0);
        chk("over_timer", 32'(o_TimerEn), 32'd0);
        set_sec(12'h006);
        step();
        chk("over_hold_disp", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'h005);

        // Goal and limit together: clear wins
        start_countdown(1'b0);
        goal_at(12'h005, 12'h001, 1'b0);

        // Asynchronous reset in the middle of play
        start_countdown(1'b0);
        set_sec(12'h002);
        step();
        #2;
        i_Rst = 1'b0;
        #1;
        chk("arst_state", 32'(o_State), 32'd0);
        chk("arst_timer", 32'(o_TimerEn), 32'd0);
        chk("arst_valid", 32'(o_BestValid), 32'd0);
        chk("arst_best", 32'({o_Best2, o_Best1, o_Best0}), 32'h000);
        chk("arst_disp", 32'({o_Disp2, o_Disp1, o_Disp0}), 32'h000);
        step();
        i_Rst = 1'b1;
        repeat (4) step();
        chk("post_rst_idle", 32'(o_State), 32'd0);
        chk("post_rst_timer", 32'(o_TimerEn), 32'd0);
        start_countdown(1'b0);
        goal_at(12'h003, 12'h003, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter CNTDN_TICK, default 99999999, clock cycles per countdown step minus one.
REQ-002 Parameter CNTDN_LEN, default 3, countdown start value (1..9).
REQ-003 Parameter TIME_LIMIT, default 12'h999, BCD time limit {Sec2,Sec1,Sec0}.
REQ-004 i_Clk  in  1  system clock; i_Rst  in  1  reset, asynchronous, active-low.
REQ-005 i_Start  in  1  single-cycle debounced start/restart pulse.
REQ-006 i_Goal  in  1  player occupies goal cell (level).
REQ-007 i_Sec0, i_Sec1, i_Sec2  in  4 each  live BCD digits from the game timer.
REQ-008 o_TimerEn  out  1  game timer enable; low also clears the timer.
REQ-009 o_State  out  3  IDLE=0, CNTDN=1, PLAY=2, CLEAR=3, OVER=4.
REQ-010 o_Cntdn  out  4  remaining countdown value, 0 outside CNTDN.
REQ-011 o_MoveEn  out  1  player movement permitted.
REQ-012 o_Disp0, o_Disp1, o_Disp2  out  4 each  displayed run time.
REQ-013 o_Best0, o_Best1, o_Best2  out  4 each  best clear time; o_BestValid  out  1; o_NewBest  out  1.

Function
REQ-014 All outputs registered; every state change takes effect the cycle after its trigger is sampled.
REQ-015 IDLE: i_Start -> CNTDN with o_Cntdn=CNTDN_LEN and tick counter=0.
REQ-016 CNTDN: tick counter counts 0..CNTDN_TICK; at CNTDN_TICK counter wraps to 0 and o_Cntdn decrements; decrement from 1 -> PLAY with o_Cntdn=0.
REQ-017 CNTDN: i_Start and i_Goal ignored.
REQ-018 o_TimerEn=1 and o_MoveEn=1 exactly while o_State=PLAY.
REQ-019 PLAY: i_Goal=1 -> CLEAR; else {i_Sec2,i_Sec1,i_Sec0}==TIME_LIMIT -> OVER; i_Start ignored.
REQ-020 Goal and limit in same cycle: CLEAR wins.
REQ-021 PLAY: o_Disp* follows i_Sec* with one cycle of register latency.
REQ-022 On PLAY exit, o_Disp* captures the i_Sec* sampled in the exit-trigger cycle and holds it through CLEAR/OVER.
REQ-023 IDLE and CNTDN: o_Disp*=0.
REQ-024 CLEAR/OVER: i_Start -> CNTDN (restart, reload as REQ-015); o_Disp* cleared on that transition.
REQ-025 Best update on PLAY->CLEAR: if o_BestValid=0 or captured time < best (12-bit unsigned compare of BCD concatenation), o_Best*<=captured, o_BestValid<=1, o_NewBest<=1.
REQ-026 o_NewBest cleared on leaving CLEAR; never set on OVER; equal time does not update.
REQ-027 Best registers retained across restarts; cleared only by reset.
REQ-028 Illegal o_State encodings -> IDLE next cycle.

Reset
REQ-029 i_Rst low: immediately o_State=IDLE, tick counter=0, all outputs 0, including o_BestValid and o_Best*.
REQ-030 Reset mid-PLAY drops o_TimerEn asynchronously; after release, stays IDLE until i_Start.

Verification (CNTDN_TICK=3, CNTDN_LEN=3, TIME_LIMIT=12'h005)
REQ-031 Start in IDLE -> o_Cntdn 3,2,1 each held 4 cycles, then PLAY with o_TimerEn=1, o_MoveEn=1; PLAY entered 12 cycles after CNTDN entry.
REQ-032 Drive i_Sec 0,0,2 then i_Goal=1 -> CLEAR, o_Disp=002, o_Best=002, o_BestValid=1, o_NewBest=1, o_TimerEn=0.
REQ-033 Restart, goal at 004 -> best stays 002, o_NewBest=0; restart, goal at 001 -> best 001, o_NewBest=1.
REQ-034 PLAY with i_Sec reaching 005, no goal -> OVER, o_Disp=005, best unchanged; i_Goal=1 with i_Sec=005 same cycle -> CLEAR.
REQ-035 i_Start pulses during CNTDN and PLAY -> no effect; i_Goal during CNTDN -> no effect.
REQ-036 Assert i_Rst mid-PLAY -> o_TimerEn=0 and o_State=IDLE without clock edge; best cleared; after release no activity until i_Start.
